// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the PicoComputer fetch path: opcode constants, the
// immediate marker, the boot address and the fetch sequencer state encoding.
package fetch_unit_pkg;

    localparam logic [3:0] OP_MOV   = 4'h0;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [3:0] IMM_MARK = 4'h8;

    localparam int DEFAULT_START_ADDR = 8;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_RD1,
        ST_LD1,
        ST_RD2,
        ST_LD2,
        ST_DONE,
        ST_HALTED
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[15:12];
    endfunction

endpackage

// File: rtl/fetch_unit_instr_len_decode.sv
// Instruction length decoder shared with the execute-stage decoder:
// classifies a first instruction word as HALT and/or two-word (MOV immediate).
module instr_len_decode
    import fetch_unit_pkg::*;
(
    input  logic [15:0] word,
    output logic        is_halt,
    output logic        is_two_word
);

    logic [3:0] opcode;
    logic       unused_mid;

    assign opcode      = opcode_of(word);
    assign unused_mid  = ^word[11:4];
    assign is_halt     = (opcode == OP_HALT);
    // HALT wins over the immediate marker, so MOV is the only two-word opcode.
    assign is_two_word = (opcode == OP_MOV) && (word[3:0] == IMM_MARK);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives PC/IR strobes and the memory read port,
// fetching one or two words per start request and flagging HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int START_ADDR = DEFAULT_START_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  mem_rdy,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  pc_ld,
    output logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  pc_inc,
    output logic [DATA_WIDTH-1:0] ir_data,
    output logic                  irh_ld,
    output logic                  irl_ld,
    output logic                  irl_cl,
    output logic                  busy,
    output logic                  done,
    output logic                  halted,
    output fetch_state_t          dbg_state
);

    // Handshake: a memory word is taken on a rising edge where mem_rd=1 and
    // mem_rdy=1; mem_rd and mem_addr stay stable until then, with no timeout.

    fetch_state_t state;
    logic         is_halt;
    logic         is_two_word;

    instr_len_decode u_len_decode (
        .word        (ir_data[15:0]),
        .is_halt     (is_halt),
        .is_two_word (is_two_word)
    );

    assign mem_addr  = mem_rd ? pc_out : '0;
    assign pc_in     = pc_ld ? ADDR_WIDTH'(START_ADDR) : '0;
    assign dbg_state = state;

    // Strobes are registered alongside the state so each one is high for the
    // whole cycle the FSM spends in the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_BOOT;
            ir_data <= '0;
            mem_rd  <= 1'b0;
            pc_ld   <= 1'b0;
            pc_inc  <= 1'b0;
            irh_ld  <= 1'b0;
            irl_ld  <= 1'b0;
            irl_cl  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            pc_ld  <= 1'b0;
            pc_inc <= 1'b0;
            irh_ld <= 1'b0;
            irl_ld <= 1'b0;
            irl_cl <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_BOOT: begin
                    // First edge raises the PC load, the second leaves BOOT.
                    if (!pc_ld) begin
                        pc_ld <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RD1;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_RD1: begin
                    if (mem_rdy) begin
                        ir_data <= mem_data;
                        state   <= ST_LD1;
                        irh_ld  <= 1'b1;
                        pc_inc  <= 1'b1;
                    end else begin
                        mem_rd <= 1'b1;
                    end
                end
                ST_LD1: begin
                    if (is_halt) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else if (is_two_word) begin
                        state  <= ST_RD2;
                        mem_rd <= 1'b1;
                    end else begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        irl_cl <= 1'b1;
                    end
                end
                ST_RD2: begin
                    if (mem_rdy) begin
                        ir_data <= mem_data;
                        state   <= ST_LD2;
                        irl_ld  <= 1'b1;
                        pc_inc  <= 1'b1;
                    end else begin
                        mem_rd <= 1'b1;
                    end
                end
                ST_LD2: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_BOOT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC register and memory model around the DUT,
// a table of fetch vectors, and hand sequences for reset, HALT and busy starts.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mem_rdy = 1'b1;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] mem_data;
    logic          mem_rd, pc_ld, pc_inc, irh_ld, irl_ld, irl_cl, busy, done, halted;
    logic [AW-1:0] mem_addr, pc_in;
    logic [DW-1:0] ir_data;
    fetch_state_t  dbg_state;

    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    // Per-run observation record
    int cyc, viol, n_pc_inc, n_pc_ld, n_done, n_rd;
    int done_cyc, halt_cyc, irh_cyc, irl_cyc, irl_cl_cyc;
    int rd_idx, wait_left;
    int waits [0:3];
    logic [AW-1:0] rd_addr [0:3];
    logic rd_active;
    logic [DW-1:0] ir_hi, ir_lo;

    typedef struct {
        logic [15:0] w1;
        logic [15:0] w2;
        int          wt1;
        int          wt2;
        logic        two;
        logic        halt;
        int          exp_end;
        logic [15:0] exp_irl;
        logic [5:0]  exp_pc;
    } vec_t;

    vec_t vecs [0:8];

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc_out    (pc_out),
        .mem_rdy   (mem_rdy),
        .mem_data  (mem_data),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .pc_ld     (pc_ld),
        .pc_in     (pc_in),
        .pc_inc    (pc_inc),
        .ir_data   (ir_data),
        .irh_ld    (irh_ld),
        .irl_ld    (irl_ld),
        .irl_cl    (irl_cl),
        .busy      (busy),
        .done      (done),
        .halted    (halted),
        .dbg_state (dbg_state)
    );

    // Clock / reset environment: PC register and combinational memory
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) pc_out <= '0;
        else if (pc_ld) pc_out <= pc_in;
        else if (pc_inc) pc_out <= pc_out + 6'd1;
    end

    assign mem_data = mem[mem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        cyc = 0; viol = 0; n_pc_inc = 0; n_pc_ld = 0; n_done = 0; n_rd = 0;
        done_cyc = -1; halt_cyc = -1; irh_cyc = -1; irl_cyc = -1; irl_cl_cyc = -1;
        rd_idx = 0; wait_left = 0; rd_active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            waits[i] = 0;
            rd_addr[i] = '1;
        end
        ir_hi = 16'hDEAD;
        ir_lo = 16'hDEAD;
        exp_q.delete();
    endtask

    // One cycle: sample at negedge, check invariants, drive mem_rdy for the next edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pc_ld && pc_inc) viol++;
        if (int'(irh_ld) + int'(irl_ld) + int'(irl_cl) > 1) viol++;
        if (!mem_rd && mem_addr != '0) viol++;
        if (mem_rd && mem_addr !== pc_out) viol++;
        if (pc_ld) begin
            n_pc_ld++;
            if (pc_in !== 6'd8) viol++;
        end else if (pc_in != '0) viol++;
        if (pc_inc) n_pc_inc++;
        if (irh_ld) begin
            irh_cyc = cyc;
            ir_hi = ir_data;
            if (exp_q.size() > 0) check("irh_word", ir_data, exp_q.pop_front());
            else viol++;
        end
        if (irl_ld) begin
            irl_cyc = cyc;
            ir_lo = ir_data;
            if (exp_q.size() > 0) check("irl_word", ir_data, exp_q.pop_front());
            else viol++;
        end
        if (irl_cl) begin
            irl_cl_cyc = cyc;
            ir_lo = '0;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (halted && halt_cyc < 0) halt_cyc = cyc;
        if (mem_rd) begin
            n_rd++;
            if (!rd_active) begin
                rd_active = 1'b1;
                rd_addr[rd_idx] = mem_addr;
                wait_left = waits[rd_idx];
            end else if (mem_addr !== rd_addr[rd_idx]) viol++;
            if (wait_left > 0) begin
                mem_rdy = 1'b0;
                wait_left--;
            end else begin
                mem_rdy = 1'b1;
            end
        end else begin
            if (rd_active) begin
                rd_active = 1'b0;
                if (rd_idx < 3) rd_idx++;
            end
            mem_rdy = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();
    endtask

    task automatic run_fetch(input int w1, input int w2);
        waits[0] = w1;
        waits[1] = w2;
        cyc = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < 40 && n_done == 0 && halt_cyc < 0) step();
        repeat (3) step();
    endtask

    initial begin
        vecs[0] = '{16'h1123, 16'h0000, 0, 0, 1'b0, 1'b0, 3, 16'h0000, 6'd9};
        vecs[1] = '{16'h0108, 16'hBEEF, 0, 0, 1'b1, 1'b0, 5, 16'hBEEF, 6'd10};
        vecs[2] = '{16'h1123, 16'h0000, 3, 0, 1'b0, 1'b0, 6, 16'h0000, 6'd9};
        vecs[3] = '{16'h0108, 16'h1234, 1, 2, 1'b1, 1'b0, 8, 16'h1234, 6'd10};
        vecs[4] = '{16'h0107, 16'hAAAA, 0, 0, 1'b0, 1'b0, 3, 16'h0000, 6'd9};
        vecs[5] = '{16'h2008, 16'hAAAA, 0, 0, 1'b0, 1'b0, 3, 16'h0000, 6'd9};
        vecs[6] = '{16'hF000, 16'h5555, 0, 0, 1'b0, 1'b1, 3, 16'hDEAD, 6'd9};
        vecs[7] = '{16'hF108, 16'h5555, 2, 0, 1'b0, 1'b1, 5, 16'hDEAD, 6'd9};
        vecs[8] = '{16'h0FF8, 16'h0001, 0, 3, 1'b1, 1'b0, 8, 16'h0001, 6'd10};
        for (int i = 0; i < 64; i++) mem[i] = 16'h7777;
        clear_rec();

        // Reset state and boot sequence
        @(negedge clk);
        check("reset_outputs", {mem_rd, pc_ld, pc_inc, irh_ld, irl_ld, irl_cl, busy, done, halted,
                                mem_addr, pc_in, ir_data}, 32'h0);
        rst = 1'b0;
        repeat (6) step();
        check("boot_pc_ld_count", n_pc_ld, 1);
        check("boot_violations", viol, 0);
        check("boot_pc", pc_out, 8);
        check("boot_busy", busy, 0);
        check("boot_state", dbg_state, ST_IDLE);

        // Table-driven fetches, each from PC=8 after a fresh reset
        for (int v = 0; v < 9; v++) begin
            mem[8] = vecs[v].w1;
            mem[9] = vecs[v].w2;
            do_reset();
            clear_rec();
            exp_q.push_back(vecs[v].w1);
            if (vecs[v].two) exp_q.push_back(vecs[v].w2);
            run_fetch(vecs[v].wt1, vecs[v].wt2);
            if (vecs[v].halt) begin
                check($sformatf("v%0d_halt_cycle", v), halt_cyc, vecs[v].exp_end);
                check($sformatf("v%0d_no_done", v), n_done, 0);
                check($sformatf("v%0d_halted", v), halted, 1);
            end else begin
                check($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_end);
                check($sformatf("v%0d_done_count", v), n_done, 1);
                check($sformatf("v%0d_idle_busy", v), {busy, halted}, 0);
                check($sformatf("v%0d_idle_state", v), dbg_state, ST_IDLE);
            end
            check($sformatf("v%0d_irh_cycle", v), irh_cyc, 2 + vecs[v].wt1);
            check($sformatf("v%0d_irh", v), ir_hi, vecs[v].w1);
            check($sformatf("v%0d_irl", v), ir_lo, vecs[v].exp_irl);
            check($sformatf("v%0d_pc", v), pc_out, vecs[v].exp_pc);
            check($sformatf("v%0d_pc_inc", v), n_pc_inc, vecs[v].two ? 2 : 1);
            check($sformatf("v%0d_addr1", v), rd_addr[0], 8);
            if (vecs[v].two) begin
                check($sformatf("v%0d_addr2", v), rd_addr[1], 9);
                check($sformatf("v%0d_irl_cycle", v), irl_cyc, 4 + vecs[v].wt1 + vecs[v].wt2);
            end else if (!vecs[v].halt) begin
                check($sformatf("v%0d_irl_cl_cycle", v), irl_cl_cyc, vecs[v].exp_end);
            end
            check($sformatf("v%0d_violations", v), viol, 0);
            check($sformatf("v%0d_queue_left", v), exp_q.size(), 0);
        end

        // HALT is sticky: later starts are ignored until rst
        mem[8] = 16'hF000;
        do_reset();
        clear_rec();
        exp_q.push_back(16'hF000);
        run_fetch(0, 0);
        n_rd = 0;
        repeat (3) begin
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (3) step();
        end
        check("halt_sticky", halted, 1);
        check("halt_state", dbg_state, ST_HALTED);
        check("halt_no_reads", n_rd, 0);
        check("halt_no_done", n_done, 0);
        check("halt_busy", busy, 0);
        #2 rst = 1'b1;
        #1 check("halt_rst_clears", {halted, ir_data}, 0);

        // Reset during the second read: mem_rd drops at once, PC reboots to 8
        mem[8] = 16'h0108;
        mem[9] = 16'hBEEF;
        do_reset();
        clear_rec();
        exp_q.push_back(16'h0108);
        waits[0] = 0;
        waits[1] = 100;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) step();
        check("rd2_in_flight", {mem_rd, mem_addr}, {1'b1, 6'd9});
        #2 rst = 1'b1;
        #1 check("rd2_rst_outputs", {mem_rd, mem_addr, irl_ld, done, busy, pc_inc}, 0);
        step();
        rst = 1'b0;
        repeat (5) step();
        check("rd2_reboot_pc_ld", n_pc_ld, 1);
        check("rd2_reboot_pc", pc_out, 8);
        check("rd2_no_done_irl", {n_done[7:0], 8'(irl_cyc + 1)}, 0);
        check("rd2_state", dbg_state, ST_IDLE);

        // start held through RD1/LD1/DONE yields exactly one fetch
        mem[8] = 16'h1123;
        do_reset();
        clear_rec();
        exp_q.push_back(16'h1123);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        step();
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        repeat (6) step();
        check("busy_start_done", n_done, 1);
        check("busy_start_pc_inc", n_pc_inc, 1);
        check("busy_start_pc", pc_out, 9);
        check("busy_start_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
